// File: rtl/pad_conditioner.sv
// pad_conditioner: clocked conditioning between board pad buffers and system logic.
//
// Inputs: each of N_IN raw pad signals is synchronised through SYNC_STAGES flops.
// It is then debounced against a shared stable-cycle threshold. The block emits a
// clean level plus one-cycle rise/fall pulses. Outputs: N_LED registered LED drives,
// each selectable as off, on, blink or PWM-dimmed.
//
// Ports:
//   clk           system clock
//   srst_n        asynchronous active-low reset
//   pad_in        raw pad inputs, asynchronous to clk
//   debounce_cnt  consecutive synchronised samples needed to accept a new level (0 acts as 1)
//   in_level      debounced level per channel
//   in_rise       one-cycle pulse when in_level goes 0->1
//   in_fall       one-cycle pulse when in_level goes 1->0
//   led_mode      per LED, bits [2i+1:2i]: 00 off, 01 on, 10 blink, 11 PWM
//   led_duty      per LED PWM duty, bits [PWM_W*i +: PWM_W]
//   led_out       registered LED drive
module pad_conditioner #(
   parameter int               N_IN        = 2,
   parameter int               SYNC_STAGES = 2,
   parameter int               DEBOUNCE_W  = 16,
   parameter logic [N_IN-1:0]  IN_RST_VAL  = {N_IN{1'b1}},
   parameter int               N_LED       = 4,
   parameter int               PWM_W       = 8,
   parameter int               BLINK_W     = 24
) (
   input  logic                    clk,
   input  logic                    srst_n,
   input  logic [N_IN-1:0]         pad_in,
   input  logic [DEBOUNCE_W-1:0]   debounce_cnt,
   output logic [N_IN-1:0]         in_level,
   output logic [N_IN-1:0]         in_rise,
   output logic [N_IN-1:0]         in_fall,
   input  logic [2*N_LED-1:0]      led_mode,
   input  logic [PWM_W*N_LED-1:0]  led_duty,
   output logic [N_LED-1:0]        led_out
);

   // True once this mismatch cycle brings the run up to the threshold.
   // The increment is one bit wider so an all-ones count cannot wrap.
   // A zero threshold is always reached, which makes 0 behave like 1.
   function automatic logic thresh_reached(input logic [DEBOUNCE_W-1:0] cnt,
                                           input logic [DEBOUNCE_W-1:0] thr);
      logic [DEBOUNCE_W:0] cnt_inc;
      cnt_inc = {1'b0, cnt} + (DEBOUNCE_W+1)'(1);
      return cnt_inc >= {1'b0, thr};
   endfunction

   // Stage p0: synchroniser chain; entry 0 samples the pad, last entry is the clean sample.
   logic [SYNC_STAGES-1:0][N_IN-1:0] sync_p0;
   logic [N_IN-1:0]                  s_p0;

   assign s_p0 = sync_p0[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         sync_p0 <= {SYNC_STAGES{IN_RST_VAL}};
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pad_in};
      end
   end

   // Stage p1: debounce counters and registered level/pulse outputs.
   logic [N_IN-1:0][DEBOUNCE_W-1:0] cnt_p1;
   logic [N_IN-1:0][DEBOUNCE_W-1:0] cnt_d;
   logic [N_IN-1:0]                 level_d;
   logic [N_IN-1:0]                 rise_d;
   logic [N_IN-1:0]                 fall_d;

   always_comb begin
      level_d = in_level;
      rise_d  = '0;
      fall_d  = '0;
      cnt_d   = '0;
      for (int i = 0; i < N_IN; i++) begin
         // Any cycle of agreement leaves cnt_d at 0, which restarts the count.
         if (s_p0[i] != in_level[i]) begin
            if (thresh_reached(cnt_p1[i], debounce_cnt)) begin
               level_d[i] = s_p0[i];
               rise_d[i]  = s_p0[i];
               fall_d[i]  = ~s_p0[i];
            end else begin
               cnt_d[i] = cnt_p1[i] + DEBOUNCE_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         cnt_p1   <= '0;
         in_level <= IN_RST_VAL;
         in_rise  <= '0;
         in_fall  <= '0;
      end else begin
         cnt_p1   <= cnt_d;
         in_level <= level_d;
         in_rise  <= rise_d;
         in_fall  <= fall_d;
      end
   end

   // LED engine: free-running counters shared by every LED.
   // All LEDs in the same mode therefore stay phase-aligned.
   logic [PWM_W-1:0]   pwm_cnt;
   logic [BLINK_W-1:0] blink_cnt;
   logic [N_LED-1:0]   led_d;

   always_comb begin
      led_d = '0;
      for (int l = 0; l < N_LED; l++) begin
         case (led_mode[2*l +: 2])
            2'b00:   led_d[l] = 1'b0;
            2'b01:   led_d[l] = 1'b1;
            2'b10:   led_d[l] = blink_cnt[BLINK_W-1];
            default: led_d[l] = led_duty[PWM_W*l +: PWM_W] > pwm_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         pwm_cnt   <= '0;
         blink_cnt <= '0;
         led_out   <= '0;
      end else begin
         pwm_cnt   <= pwm_cnt + PWM_W'(1);
         blink_cnt <= blink_cnt + BLINK_W'(1);
         led_out   <= led_d;
      end
   end

endmodule

// File: doc/pad_conditioner.md
# pad_conditioner

Parametrised board-I/O conditioner between the pad buffers and system logic, generalising the fixed JTAG/LED pad wrapper. Takes N_IN raw asynchronous pad inputs, synchronises and debounces each, and emits a clean level plus one-cycle rise/fall pulses. Drives N_LED registered LED outputs, each independently selectable as off, on, blink or PWM dimmed. Pad buffer cells stay outside this block; it is purely clocked logic.

## Interface
- N_IN, 2, number of conditioned input channels
- SYNC_STAGES, 2, synchroniser flops per input (≥2)
- DEBOUNCE_W, 16, width of debounce threshold/counter
- IN_RST_VAL, {N_IN{1'b1}}, per-channel reset value of in_level (default: inactive for active-low pads)
- N_LED, 4, number of LED channels
- PWM_W, 8, PWM counter/duty width
- BLINK_W, 24, blink counter width; blink period 2^BLINK_W cycles
- clk  in  1  system clock
- srst_n  in  1  reset, asynchronous assert, active-low
- pad_in  in  N_IN  raw pad-side inputs, asynchronous to clk
- debounce_cnt  in  DEBOUNCE_W  stable-cycles threshold, shared by all inputs; 0 = bypass
- in_level  out  N_IN  debounced level
- in_rise  out  N_IN  one-cycle pulse on in_level 0→1
- in_fall  out  N_IN  one-cycle pulse on in_level 1→0
- led_mode  in  2*N_LED  per LED, bits [2i+1:2i]: 00 off, 01 on, 10 blink, 11 PWM
- led_duty  in  PWM_W*N_LED  per-LED duty, bits [PWM_W*i +: PWM_W]
- led_out  out  N_LED  registered LED drive to output pads

## Operation
- Reset (srst_n low, async): sync flops ← IN_RST_VAL, in_level ← IN_RST_VAL, debounce counters ← 0, in_rise/in_fall ← 0, pwm_cnt ← 0, blink_cnt ← 0, led_out ← 0. Release is used synchronously by downstream logic; no glitch on outputs during reset.
- Synchroniser: per channel, SYNC_STAGES-deep flop chain; s[i] = last stage.
- Debounce per channel, counter cnt[i] (DEBOUNCE_W bits):
  - s[i] == in_level[i]: cnt ← 0, no change.
  - s[i] != in_level[i] and cnt+1 ≥ debounce_cnt: in_level ← s[i], cnt ← 0, assert in_rise or in_fall for that cycle.
  - otherwise: cnt ← cnt+1 (cannot overflow: flip occurs at threshold).
  - debounce_cnt = 0 behaves as 1: level follows s with one register delay.
  - Any single cycle of agreement restarts the count (glitch rejection).
  - debounce_cnt lowered mid-count: ≥ compare flips on the next mismatch cycle; raised: count continues toward new threshold.
- in_rise/in_fall registered, high exactly one cycle, coincident with the in_level transition; never both high on one channel.
- LED engine: pwm_cnt free-running PWM_W-bit, wraps 2^PWM_W−1→0; blink_cnt free-running BLINK_W-bit.
  - off: led_out ← 0; on: led_out ← 1; blink: led_out ← blink_cnt[BLINK_W−1]; PWM: led_out ← (duty > pwm_cnt).
  - duty 0 → always 0; duty 2^PWM_W−1 → high 2^PWM_W−1 of every 2^PWM_W cycles.
  - Mode/duty changes take effect on next clock; counters are never reset by mode changes, so all LEDs in the same mode stay phase-aligned.

## Timing
- Input latency, pad edge to in_level/pulse: SYNC_STAGES + max(debounce_cnt,1) rising edges (±1 for async sampling).
- Pulse needed for acceptance: pad must be stable for ≥ debounce_cnt consecutive synchronised samples.
- LED latency: led_mode/led_duty to led_out: 1 cycle. led_out is a flop output, no combinational path from any input.
- PWM period 2^PWM_W cycles; blink period 2^BLINK_W cycles, 50% duty.
- Mid-operation reset: all state returns to reset values immediately regardless of pending debounce counts; no pulse emitted on reset entry or exit.

## Test plan
- Reset: hold srst_n low with pad_in = 0 → in_level = 2'b11, in_rise = in_fall = 0, led_out = 0; release, pad_in held 2'b11 → no pulses for 100 cycles.
- Clean edge, debounce_cnt = 4: pad_in[0] 1→0 held → in_level[0] falls and in_fall[0] pulses exactly 1 cycle, 6 edges (2 sync + 4) after sampling; channel 1 unaffected.
- Glitch rejection, debounce_cnt = 4: pad_in[1] low 3 cycles then high → no change, no pulse; low 4 cycles → in_fall[1] once, then in_rise[1] after return high stable 4 cycles.
- Bypass, debounce_cnt = 0: 1-cycle-wide pad pulse (after sync) → in_level follows with 1-cycle delay; rise then fall pulses on consecutive transitions.
- LED modes, PWM_W = 8, BLINK_W = 4: LED0 off → 0; LED1 on → 1; LED2 blink → 8 high/8 low repeating; LED3 PWM duty 64 → exactly 64 high per 256 cycles; duty 0 → never high; duty 255 → 255 high.
- Reset mid-debounce: debounce_cnt = 10, pad change held 5 cycles, assert srst_n → outputs at reset values at once; after release with pad still changed, full 2+10 cycle latency restarts, single pulse.
